// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, ALUOp classes and execute-unit FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ADDI  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - XLEN-cycle shift-add multiplier, low half of the product.
// Only instantiated when ALU_MUL_EN is defined.
module alu_mul_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_product
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

    logic            r_busy;
    logic [CW-1:0]   r_step;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] w_partial;

    // The final step's sum is exposed combinationally so the caller can
    // register it on the same edge that retires step XLEN-1.
    assign w_partial = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_product = w_partial;
    assign o_busy    = r_busy;
    assign o_done    = r_busy && (r_step == LAST_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_step   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_step   <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
        end else if (r_busy) begin
            r_acc    <= w_partial;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_step == LAST_STEP) begin
                r_busy <= 1'b0;
                r_step <= '0;
            end else begin
                r_step <= r_step + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - handshaked ALU execute unit with registered result.
// Define ALU_MUL_EN to build the iterative multiplier and the EXEC state.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [6:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      ALUControl,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int SHW = $clog2(XLEN);

    alu_state_e      r_state;
    logic [3:0]      r_ctrl;
    logic [XLEN-1:0] r_result;
    logic [3:0]      w_ctrl;
    logic [XLEN-1:0] w_alu;
    logic            w_accept;

    function automatic logic [3:0] alu_decode(input logic [1:0] aluop, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [6:0] opc);
        logic [3:0] c;
        c = ALU_ADD;
        case (aluop)
            ALUOP_ADD:   c = ALU_ADD;
            ALUOP_SUB:   c = ALU_SUB;
            ALUOP_ADDI:  c = ALU_ADD;
            ALUOP_FUNCT: begin
                case (f3)
                    3'b000: begin
`ifdef ALU_MUL_EN
                        if (opc[5] && f7 == 7'b0000001) c = ALU_MUL;
                        else
`endif
                        if (opc[5] && f7[5]) c = ALU_SUB;
                        else c = ALU_ADD;
                    end
                    3'b001:  c = ALU_SLL;
                    3'b010:  c = ALU_SLT;
                    3'b011:  c = ALU_SLTU;
                    3'b100:  c = ALU_XOR;
                    3'b101:  c = f7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  c = ALU_OR;
                    default: c = ALU_AND;
                endcase
            end
            default:     c = ALU_ADD;
        endcase
        return c;
    endfunction

    function automatic logic [XLEN-1:0] alu_compute(input logic [3:0] c, input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b);
        logic [XLEN-1:0] y;
        logic [SHW-1:0]  sh;
        sh = b[SHW-1:0];
        case (c)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLL:  y = a << sh;
            ALU_SRL:  y = a >> sh;
            ALU_SRA:  y = $unsigned($signed(a) >>> sh);
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
            default:  y = '0;
        endcase
        return y;
    endfunction

    always_comb begin
        w_ctrl = alu_decode(ALUOp, funct3, funct7, op);
        w_alu  = alu_compute(w_ctrl, src_a, src_b);
    end

    // in_ready is a function of state and out_ready only, never of in_valid.
    assign in_ready   = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = (r_state == DONE);
    assign result     = r_result;
    assign ALUControl = r_ctrl;
    assign zero       = (r_result == '0);

`ifdef ALU_MUL_EN
    logic            w_mul_start;
    logic            w_mul_busy;
    logic            w_mul_done;
    logic [XLEN-1:0] w_mul_prod;

    assign w_mul_start = w_accept && (w_ctrl == ALU_MUL);

    alu_mul_iter #(.XLEN(XLEN)) u_mul (
        .clk       (clk),
        .rst_n     (rst),
        .i_start   (w_mul_start),
        .i_a       (src_a),
        .i_b       (src_b),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_ctrl   <= ALU_ADD;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_ctrl <= w_ctrl;
`ifdef ALU_MUL_EN
                        if (w_ctrl == ALU_MUL) r_state <= EXEC;
                        else
`endif
                        begin
                            r_result <= w_alu;
                            r_state  <= DONE;
                        end
                    end else if (r_state == DONE && out_ready) begin
                        r_state <= IDLE;
                    end
                end
`ifdef ALU_MUL_EN
                EXEC: begin
                    // An idle multiplier here would mean a lost start; recover rather than hang.
                    if (w_mul_done || !w_mul_busy) begin
                        r_result <= w_mul_prod;
                        r_state  <= DONE;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit (default and ALU_MUL_EN builds).
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  ALUOp = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [6:0]  op = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  ALUControl;
    logic [31:0] result;
    logic        zero;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int next_id = 0;
    int last_acc = 0;

    logic [3:0]  q_ctrl[$];
    logic [31:0] q_res[$];
    int          q_acc[$];
    int          q_lat[$];
    int          q_id[$];

    alu_exec_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUOp      (ALUOp),
        .funct3     (funct3),
        .funct7     (funct7),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUControl (ALUControl),
        .result     (result),
        .zero       (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    task automatic issue(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [6:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] ectrl, input logic [31:0] eres, input int lat);
        int waited;
        @(negedge clk);
        ALUOp = aop; funct3 = f3; funct7 = f7; op = opc; src_a = a; src_b = b;
        in_valid = 1'b1;
        #1;
        waited = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            chk("issue_accept_timeout", {31'b0, in_ready}, 32'd1);
            return;
        end
        q_ctrl.push_back(ectrl);
        q_res.push_back(eres);
        q_acc.push_back(cyc);
        q_lat.push_back(lat);
        q_id.push_back(next_id);
        next_id++;
        last_acc = cyc;
        @(posedge clk);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q_res.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        chk("scoreboard_drained", q_res.size(), 32'd0);
    endtask

    task automatic discard_last();
        void'(q_ctrl.pop_back());
        void'(q_res.pop_back());
        void'(q_acc.pop_back());
        void'(q_lat.pop_back());
        void'(q_id.pop_back());
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"},  {31'b0, out_valid}, 32'd0);
        chk({tag, "_in_ready"},   {31'b0, in_ready},  32'd1);
        chk({tag, "_result"},     result,             32'd0);
        chk({tag, "_zero"},       {31'b0, zero},      32'd1);
        chk({tag, "_ALUControl"}, {28'b0, ALUControl}, 32'd0);
    endtask

    // Monitor: pop and compare on every handoff, independent of the driver.
    initial begin
        logic [3:0]  e_ctrl;
        logic [31:0] e_res;
        int          e_acc, e_lat, e_id;
        forever begin
            @(negedge clk); #2;
            if (rst && out_valid && out_ready) begin
                if (q_res.size() == 0) begin
                    chk("unexpected_output", result, 32'hxxxxxxxx);
                end else begin
                    e_ctrl = q_ctrl.pop_front();
                    e_res  = q_res.pop_front();
                    e_acc  = q_acc.pop_front();
                    e_lat  = q_lat.pop_front();
                    e_id   = q_id.pop_front();
                    chk($sformatf("v%0d_result", e_id), result, e_res);
                    chk($sformatf("v%0d_ALUControl", e_id), {28'b0, ALUControl}, {28'b0, e_ctrl});
                    chk($sformatf("v%0d_zero", e_id), {31'b0, zero}, {31'b0, (e_res == 32'd0)});
                    if (e_lat >= 0)
                        chk($sformatf("v%0d_latency", e_id), cyc - e_acc, e_lat);
                end
            end
        end
    end

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    initial begin
        int first_acc;

        // Reset held across two edges.
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk_reset_state("por");
        rst = 1'b1;
        out_ready = 1'b1;

        // Back-to-back single-cycle ops with out_ready held high.
        issue(2'b10, 3'b000, F7_ALT, OP_R, 32'd5, 32'd7, 4'b0001, 32'hFFFFFFFE, 1);
        first_acc = last_acc;
        issue(2'b10, 3'b101, F7_ALT, OP_R, 32'h80000000, 32'd4, 4'b1001, 32'hF8000000, 1);
        issue(2'b10, 3'b101, 7'd0,   OP_R, 32'h80000000, 32'd4, 4'b1000, 32'h08000000, 1);
        issue(2'b10, 3'b010, 7'd0,   OP_R, 32'hFFFFFFFF, 32'd1, 4'b0101, 32'd1, 1);
        issue(2'b10, 3'b011, 7'd0,   OP_R, 32'hFFFFFFFF, 32'd1, 4'b0110, 32'd0, 1);
        issue(2'b10, 3'b111, 7'd0,   OP_R, 32'h0000F0F0, 32'h0000FF00, 4'b0010, 32'h0000F000, 1);
        issue(2'b10, 3'b110, 7'd0,   OP_R, 32'h0000F0F0, 32'h0000FF00, 4'b0011, 32'h0000FFF0, 1);
        issue(2'b10, 3'b100, 7'd0,   OP_R, 32'h0000F0F0, 32'h0000FF00, 4'b0111, 32'h00000FF0, 1);
        issue(2'b10, 3'b001, 7'd0,   OP_R, 32'd1, 32'd35, 4'b0100, 32'd8, 1);
        issue(2'b00, 3'b111, F7_ALT, OP_R, 32'hFFFFFFFF, 32'd1, 4'b0000, 32'd0, 1);
        issue(2'b01, 3'b000, 7'd0,   OP_R, 32'd3, 32'd3, 4'b0001, 32'd0, 1);
        issue(2'b11, 3'b101, F7_ALT, OP_I, 32'd10, 32'd20, 4'b0000, 32'd30, 1);
        issue(2'b10, 3'b000, F7_ALT, OP_I, 32'd5, 32'd7, 4'b0000, 32'd12, 1);
        chk("b2b_throughput", last_acc - first_acc, 32'd12);
        drop_valid();
        drain();

        // Multiply encoding.
`ifdef ALU_MUL_EN
        issue(2'b10, 3'b000, 7'b0000001, OP_R, 32'h0000FFFF, 32'h00010001, 4'b1010, 32'hFFFFFFFF, 33);
        @(negedge clk); #1;
        chk("exec_in_ready", {31'b0, in_ready}, 32'd0);
        chk("exec_out_valid", {31'b0, out_valid}, 32'd0);
        in_valid = 1'b0;
`else
        issue(2'b10, 3'b000, 7'b0000001, OP_R, 32'h0000FFFF, 32'h00010001, 4'b0000, 32'h00020000, 1);
        drop_valid();
`endif
        drain();

        // Backpressure: held result, in_ready low, then handoff plus accept in one edge.
        out_ready = 1'b0;
        issue(2'b00, 3'b000, 7'd0, OP_R, 32'd1, 32'd2, 4'b0000, 32'd3, -1);
        @(negedge clk);
        ALUOp = 2'b01; src_a = 32'd10; src_b = 32'd4; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            chk($sformatf("bp%0d_in_ready", i), {31'b0, in_ready}, 32'd0);
            chk($sformatf("bp%0d_result", i), result, 32'd3);
            chk($sformatf("bp%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        q_ctrl.push_back(4'b0001);
        q_res.push_back(32'd6);
        q_acc.push_back(cyc);
        q_lat.push_back(1);
        q_id.push_back(next_id);
        next_id++;
        @(posedge clk);
        drop_valid();
        drain();

        // Asynchronous reset with a request in flight.
        out_ready = 1'b0;
`ifdef ALU_MUL_EN
        issue(2'b10, 3'b000, 7'b0000001, OP_R, 32'd3, 32'd4, 4'b1010, 32'd12, -1);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
`else
        issue(2'b00, 3'b000, 7'd0, OP_R, 32'd1, 32'd1, 4'b0000, 32'd2, -1);
        #1 in_valid = 1'b0;
        @(negedge clk); #1;
        chk("held_before_reset", result, 32'd2);
`endif
        rst = 1'b0;
        discard_last();
        #1;
        chk_reset_state("async_rst");
        @(posedge clk); #2;
        chk_reset_state("rst_next_cycle");
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        issue(2'b01, 3'b000, 7'd0, OP_R, 32'd9, 32'd2, 4'b0001, 32'd7, 1);
        drop_valid();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: cycle=%0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised, handshaked successor to the combinational ALU decoder. Decodes ALUOp/funct3/funct7/op into an extended 4-bit ALU control code, executes the operation on XLEN-bit operands, and returns a registered result. Every RV32I ALU op completes in one cycle; an optional iterative multiplier runs for XLEN cycles. Sits in the execute stage between the main decoder and writeback, behind valid/ready handshakes on both sides.

## Interface
- XLEN, 32, operand/result width (≥8, power of two)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request this cycle
- ALUOp  in  2  main-decoder ALU class
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7
- op  in  7  instruction opcode
- src_a, src_b  in  XLEN  operands
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- ALUControl  out  4  registered control code of the held result
- result  out  XLEN  registered result
- zero  out  1  result == 0

## Operation
- Codes: ADD 0000, SUB 0001, AND 0010, OR 0011, SLL 0100, SLT 0101, SLTU 0110, XOR 0111, SRL 1000, SRA 1001, MUL 1010.
- Decode: ALUOp 00 → ADD; 01 → SUB; 11 → ADD. ALUOp 10 by funct3:
  - 000 → SUB if {op[5],funct7[5]}==11, else ADD
  - 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 110 OR; 111 AND
  - 101 → SRA if funct7[5], else SRL
- Shift amount is src_b[log2(XLEN)-1:0]. SLT is signed, SLTU unsigned; both produce 1 or 0, zero-extended.
- Arithmetic wraps modulo 2^XLEN. MUL returns the low XLEN bits.
- FSM states:
  - IDLE: in_ready=1. On in_valid, decode. MUL → EXEC; any other op → result registered, go to DONE.
  - EXEC: one shift-add step per cycle, step counter 0..XLEN-1. After step XLEN-1 → DONE.
  - DONE: out_valid=1; result, zero and ALUControl are held stable. On out_ready: if in_valid, accept the new request (same rules as IDLE); otherwise → IDLE.
- in_ready = IDLE | (DONE & out_ready).
- Input fields are sampled only on acceptance and may change afterwards.

## Timing
- Reset (asynchronous, any state, including mid-EXEC): state=IDLE, out_valid=0, result=0, ALUControl=0000, zero=1, step counter=0. Any in-flight MUL is discarded.
- Non-MUL op: accepted in cycle N, out_valid=1 in cycle N+1.
- MUL: accepted in cycle N, out_valid=1 in cycle N+XLEN+1.
- Back-to-back single-cycle ops give one result per cycle when out_ready is held high.
- Backpressure: while out_ready=0 in DONE, the result is held indefinitely and in_ready=0.
- in_ready never depends combinationally on in_valid.

## Configuration
- ALU_MUL_EN defined:
  - {op[5],funct7}=={1,0000001} with funct3=000 and ALUOp=10 decodes to MUL.
  - The EXEC state and the multiplier are built.
- ALU_MUL_EN undefined:
  - That encoding decodes as ADD (funct7[5]=0).
  - No EXEC state or multiplier hardware; every op has 1-cycle latency.

## Structure
- Package alu_pkg holds: the 4-bit ALU control code localparams, the FSM state enum (IDLE, EXEC, DONE), and the ALUOp class constants.
- Sub-module alu_mul_iter: XLEN-parametrised shift-add multiplier. Interface: start, operands, busy/done, product low half. Instantiated only under ALU_MUL_EN.
- Decode is a combinational function in the top module.

## Test plan
- Reset mid-MUL (cycle 5 of EXEC) → next cycle out_valid=0, in_ready=1, result=0, zero=1.
- ALUOp=10, funct3=000, op=0110011, funct7=0100000, a=5, b=7 → one cycle later ALUControl=0001, result=0xFFFFFFFE, zero=0.
- funct3=101, funct7=0100000, a=0x80000000, b=4 → SRA, result=0xF8000000; with funct7=0 → SRL, result=0x08000000.
- SLT a=0xFFFFFFFF, b=1 → result=1; SLTU with the same operands → result=0.
- With ALU_MUL_EN: MUL a=0xFFFF, b=0x10001 → out_valid exactly 33 cycles after acceptance, result=0xFFFFFFFF. Without the macro, the same encoding → ADD, result=0x20000, 1-cycle latency.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1 → result held and in_ready=0. Raising out_ready hands off the held result and accepts the next request in the same cycle.
